// File: rtl/data_memory_unit.sv
// MEM-stage data memory: byte/halfword/word little-endian loads and stores,
// combinational extended read data, misalignment detection and a debug read port.
module data_memory_unit #(
   parameter int unsigned NBITS  = 32,
   parameter int unsigned NWORDS = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [NBITS-1:0]  i_addr,
   input  logic [NBITS-1:0]  i_wdata,
   input  logic              i_memread,
   input  logic              i_memwrite,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [NBITS-1:0]  o_rdata,
   output logic              o_misalign,
   output logic              o_misalign_err,
   output logic [NBITS-1:0]  o_dbg_data
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   logic [NWORDS-1:0][NBITS-1:0] mem_q, mem_d;
   logic                         err_q, err_d;

   logic [ADDR_W-1:0] idx_c;
   logic [1:0]        lane_c;
   logic              is_byte_c, is_half_c, misaligned_c, we_c;
   logic [NBITS-1:0]  word_c, wr_word_c;
   logic [BYTE_W-1:0] byte_c;
   logic [HALF_W-1:0] half_c;
   logic              unused_addr_c;

   // Address decode; upper address bits are dropped so accesses wrap.
   always_comb begin
      idx_c         = i_addr[ADDR_W+1:2];
      lane_c        = i_addr[1:0];
      is_byte_c     = (i_size == 2'b00);
      is_half_c     = (i_size == 2'b01);
      misaligned_c  = (is_half_c & lane_c[0]) |
                      (!is_byte_c & !is_half_c & (lane_c != 2'b00));
      o_misalign    = (i_memread | i_memwrite) & misaligned_c;
      we_c          = i_memwrite & i_enable & !misaligned_c & !i_reset;
      unused_addr_c = ^i_addr[NBITS-1:ADDR_W+2];
   end

   // Load path: lane select plus sign/zero extension.
   always_comb begin
      word_c  = mem_q[idx_c];
      byte_c  = word_c[{lane_c, 3'b000} +: BYTE_W];
      half_c  = word_c[{lane_c[1], 4'b0000} +: HALF_W];
      o_rdata = '0;
      if (i_memread && !misaligned_c) begin
         if (is_byte_c)
            o_rdata = {{(NBITS-BYTE_W){byte_c[BYTE_W-1] & !i_unsigned}}, byte_c};
         else if (is_half_c)
            o_rdata = {{(NBITS-HALF_W){half_c[HALF_W-1] & !i_unsigned}}, half_c};
         else
            o_rdata = word_c;
      end
   end

   // Store path: merge new lanes into the current word.
   always_comb begin
      wr_word_c = word_c;
      if (is_byte_c)
         wr_word_c[{lane_c, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
      else if (is_half_c)
         wr_word_c[{lane_c[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
      else
         wr_word_c = i_wdata;

      mem_d = mem_q;
      if (we_c)
         mem_d[idx_c] = wr_word_c;
      err_d = err_q | (o_misalign & i_enable);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mem_q <= '0;
         err_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         err_q <= err_d;
      end
   end

   assign o_misalign_err = err_q;
   assign o_dbg_data     = mem_q[i_dbg_addr];

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: byte-array reference model, directed
// sequence followed by randomized loads/stores.
module tb_data_memory_unit;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b11;

   logic        i_clk = 1'b0;
   logic        i_reset, i_enable, i_memread, i_memwrite, i_unsigned;
   logic [31:0] i_addr, i_wdata;
   logic [1:0]  i_size;
   logic [5:0]  i_dbg_addr;
   logic [31:0] o_rdata, o_dbg_data;
   logic        o_misalign, o_misalign_err;

   data_memory_unit dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_addr        (i_addr),
      .i_wdata       (i_wdata),
      .i_memread     (i_memread),
      .i_memwrite    (i_memwrite),
      .i_size        (i_size),
      .i_unsigned    (i_unsigned),
      .i_dbg_addr    (i_dbg_addr),
      .o_rdata       (o_rdata),
      .o_misalign    (o_misalign),
      .o_misalign_err(o_misalign_err),
      .o_dbg_data    (o_dbg_data)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        err;
      logic [31:0] dbg;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  mem_b [256];
   logic        err_m;
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic bit mis_f(input logic [1:0] size, input logic [7:0] a);
      if (size == SZ_B) return 1'b0;
      if (size == SZ_H) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   function automatic logic [31:0] word_at(input logic [7:0] base);
      logic [7:0] b0, b1, b2, b3;
      b0 = base; b1 = base + 8'd1; b2 = base + 8'd2; b3 = base + 8'd3;
      return {mem_b[b3], mem_b[b2], mem_b[b1], mem_b[b0]};
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] addr, input bit rd,
                                              input logic [1:0] size, input bit uns);
      logic [7:0]  a, a1;
      logic [15:0] h;
      a  = addr[7:0];
      a1 = a + 8'd1;
      if (!rd || mis_f(size, a)) return 32'd0;
      if (size == SZ_B) return uns ? {24'd0, mem_b[a]} : {{24{mem_b[a][7]}}, mem_b[a]};
      if (size == SZ_H) begin
         h = {mem_b[a1], mem_b[a]};
         return uns ? {16'd0, h} : {{16{h[15]}}, h};
      end
      return word_at(a);
   endfunction

   task automatic model_edge(input bit rst, input bit en, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit rd, input bit wr,
                             input logic [1:0] size);
      logic [7:0] a;
      int         n;
      a = addr[7:0];
      if (rst) begin
         foreach (mem_b[k]) mem_b[k] = 8'd0;
         err_m = 1'b0;
      end else if (en) begin
         if ((rd || wr) && mis_f(size, a)) err_m = 1'b1;
         if (wr && !mis_f(size, a)) begin
            n = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
            for (int k = 0; k < n; k++) mem_b[8'(a + 8'(k))] = wdata[8*k +: 8];
         end
      end
   endtask

   // One cycle of stimulus: drive, record expectation, let the edge happen.
   task automatic step(input bit rst, input bit en, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit rd, input bit wr,
                       input logic [1:0] size, input bit uns, input logic [5:0] dbg);
      exp_t e;
      i_reset = rst; i_enable = en; i_addr = addr; i_wdata = wdata;
      i_memread = rd; i_memwrite = wr; i_size = size; i_unsigned = uns; i_dbg_addr = dbg;
      e.rdata = model_load(addr, rd, size, uns);
      e.mis   = (rd || wr) && mis_f(size, addr[7:0]);
      e.err   = err_m;
      e.dbg   = word_at({dbg, 2'b00});
      sb_q.push_back(e);
      @(posedge i_clk);
      model_edge(rst, en, addr, wdata, rd, wr, size);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are combinational, compare mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rdata",        o_rdata,               e.rdata);
            check("misalign",     32'(o_misalign),       32'(e.mis));
            check("misalign_err", 32'(o_misalign_err),   32'(e.err));
            check("dbg_data",     o_dbg_data,            e.dbg);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, %0d entries pending", sb_q.size());
      $fatal(1);
   end

   initial begin
      bit          rst, en, rd, wr, uns;
      logic [31:0] addr;
      logic [1:0]  size;
      int          op;

      i_reset = 1'b1; i_enable = 1'b1; i_addr = '0; i_wdata = '0;
      i_memread = 1'b0; i_memwrite = 1'b0; i_size = SZ_W; i_unsigned = 1'b0; i_dbg_addr = '0;
      repeat (2) @(posedge i_clk);
      model_edge(1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, SZ_W);
      #1;

      for (int i = 0; i < 64; i++) step(0, 1, 32'd0, 32'd0, 0, 0, SZ_W, 0, 6'(i));

      step(0, 1, 32'h10, 32'h8899AABB, 0, 1, SZ_W, 0, 6'd4);
      step(0, 1, 32'h10, 32'd0,        1, 0, SZ_W, 0, 6'd4);
      step(0, 1, 32'h11, 32'd0,        1, 0, SZ_B, 0, 6'd4);
      step(0, 1, 32'h11, 32'd0,        1, 0, SZ_B, 1, 6'd4);
      step(0, 1, 32'h12, 32'd0,        1, 0, SZ_H, 0, 6'd4);
      step(0, 1, 32'h12, 32'd0,        1, 0, SZ_H, 1, 6'd4);
      step(0, 1, 32'h13, 32'h12345677, 0, 1, SZ_B, 0, 6'd4);
      step(0, 1, 32'h10, 32'd0,        1, 0, SZ_W, 0, 6'd4);
      step(0, 1, 32'h10, 32'h0000CAFE, 0, 1, SZ_H, 0, 6'd4);
      step(0, 1, 32'h10, 32'h11111111, 1, 1, SZ_W, 0, 6'd4);
      step(0, 1, 32'h10, 32'd0,        1, 0, SZ_W, 0, 6'd4);

      step(0, 1, 32'h22, 32'hDEADBEEF, 0, 1, SZ_W, 0, 6'd8);
      step(0, 1, 32'h20, 32'd0,        1, 0, SZ_W, 0, 6'd8);
      step(0, 1, 32'h24, 32'h01020304, 0, 1, SZ_W, 0, 6'd9);
      step(0, 1, 32'h21, 32'd0,        1, 0, SZ_H, 0, 6'd9);
      step(0, 1, 32'h20, 32'd0,        1, 0, SZ_B, 0, 6'd8);

      step(1, 1, 32'd0,  32'd0,        0, 0, SZ_W, 0, 6'd0);
      step(0, 0, 32'h22, 32'hDEADBEEF, 0, 1, SZ_W, 0, 6'd8);
      step(0, 0, 32'h20, 32'hCAFEF00D, 1, 1, SZ_W, 0, 6'd8);
      step(0, 1, 32'h20, 32'd0,        1, 0, SZ_W, 0, 6'd8);

      step(0, 1, 32'h104, 32'h0BADF00D, 0, 1, SZ_W, 0, 6'd1);
      step(0, 1, 32'h4,   32'd0,        1, 0, SZ_W, 0, 6'd1);
      step(1, 1, 32'h30,  32'h55AA55AA, 0, 1, SZ_W, 0, 6'd12);
      step(0, 1, 32'h30,  32'd0,        1, 0, SZ_W, 0, 6'd12);
      step(0, 1, 32'h4,   32'd0,        1, 0, SZ_W, 0, 6'd1);

      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         en   = ($urandom_range(0, 7) != 0);
         size = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = (size == SZ_B) ? addr[1:0] :
                                                    (size == SZ_H) ? {addr[1], 1'b0} : 2'b00;
         op   = $urandom_range(0, 3);
         rd   = (op == 1) || (op == 3);
         wr   = (op == 2) || (op == 3);
         uns  = 1'($urandom_range(0, 1));
         step(rst, en, addr, $urandom, rd, wr, size, uns, 6'($urandom_range(0, 63)));
      end

      repeat (2) @(negedge i_clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- MEM-stage data memory: services load/store instructions from the EX/MEM latch.
- Produces the loaded word, already sign- or zero-extended, for the MEM-stage result mux, which selects between it and the ALU result before the MEM/WB latch.
- Supports byte, halfword and word accesses, little-endian.
- Flags misaligned accesses.
- Provides a read-only debug port so the debug unit can dump memory contents.

Parameters:
- NBITS, 32, data/address width
- NWORDS, 64, number of 32-bit words in the array (power of 2)
- ADDR_W, 6, word-index width, log2(NWORDS)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline step enable from debug unit; 0 = freeze (no writes, error flag holds)
- i_addr  in  NBITS  byte address (ALU result)
- i_wdata  in  NBITS  store data (rt value), aligned in the low bits
- i_memread  in  1  load access
- i_memwrite  in  1  store access
- i_size  in  2  00 byte, 01 halfword, 11 word; 10 treated as word
- i_unsigned  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend
- i_dbg_addr  in  ADDR_W  debug word index
- o_rdata  out  NBITS  extended load data
- o_misalign  out  1  current access misaligned (combinational)
- o_misalign_err  out  1  sticky misalignment error
- o_dbg_data  out  NBITS  word at i_dbg_addr

Behaviour:
- Word index = i_addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo NWORDS*4.
- Byte lane = i_addr[1:0]; little-endian (lane 0 = bits 7:0).
- Misaligned:
  - halfword with i_addr[0]=1
  - word with i_addr[1:0]!=00
  - byte accesses are never misaligned
- o_misalign = (i_memread | i_memwrite) & misaligned; combinational.
- Reads are combinational: o_rdata reflects the array contents before the next rising edge, so load data is valid in the same cycle for the result mux.
  - Byte: selected lane, extended from bit 7.
  - Halfword: lane pair {addr[1],0}, extended from bit 15.
  - Word: full word, no extension.
  - i_memread=0 or misaligned load: o_rdata = 0.
- Writes occur at the rising edge when i_memwrite & i_enable & !misaligned & !i_reset.
  - Byte: writes only the addressed lane with i_wdata[7:0].
  - Halfword: writes lanes {addr[1],0} and {addr[1],1} with i_wdata[15:0].
  - Word: writes all lanes.
  - Untouched lanes keep their value.
- Misaligned stores are suppressed; the array is unchanged.
- i_memread and i_memwrite both high: the write proceeds, and o_rdata in that cycle shows the pre-write contents.
- Debug port: o_dbg_data = array[i_dbg_addr], combinational, and is available regardless of i_enable. A same-cycle write to the same word appears on the port only after the edge.
- o_misalign_err is set at the edge when o_misalign & i_enable, and holds until reset.
- Reset (synchronous, takes priority over writes):
  - all NWORDS words cleared to 0 in one cycle
  - o_misalign_err cleared to 0
  - after reset, o_rdata = 0 and o_dbg_data = 0
- Reset asserted mid-operation: a store in the same cycle is discarded.
- i_enable=0: no writes and no error-flag update; reads and the debug port remain live.

Test Plan:
- Reset, then sweep i_dbg_addr 0..63 -> o_dbg_data = 0 for all words; o_misalign_err = 0.
- SW 0x8899AABB at addr 0x10, then LW at 0x10 -> o_rdata = 0x8899AABB; o_dbg_data(idx 4) = 0x8899AABB.
- Byte loads from the same word:
  - LB at 0x11 -> 0xFFFFFFAA
  - LBU at 0x11 -> 0x000000AA
  - LH at 0x12 -> 0xFFFF8899
  - LHU at 0x12 -> 0x00008899
- SB 0x12345677 at 0x13, then LW at 0x10 -> 0x7799AABB (only lane 3 changed). SH 0xCAFE at 0x10, then LW -> 0x7799CAFE.
- SW at 0x22 -> o_misalign = 1, word idx 8 unchanged, o_misalign_err = 1 and stays 1 across later aligned accesses; LH at 0x21 -> o_rdata = 0. Repeat with i_enable=0: no flag set and no write.
- SW at 0x104 (wraps to idx 1) -> o_dbg_data(idx 1) updated. Assert i_reset in the same cycle as another SW -> the word stays 0.
